// File: rtl/cordic_pkg.sv
// Shared constants, tag type and arctangent table for the sine/cosine CORDIC
// wrapper and core.
package cordic_pkg;

  localparam int CORDIC_WIDTH   = 16;
  localparam int CORDIC_LATENCY = 16;

  // CORDIC gain 0.60725 in Q1.14, preloaded into the core x start value.
  localparam logic [15:0] GAIN_INIT_Q14 = 16'h26DD;

  // Angle encoding: full circle = 2^16, so 0x4000 is 90 degrees.
  localparam logic [15:0] ANGLE_90  = 16'h4000;
  localparam logic [15:0] ANGLE_180 = 16'h8000;

  // Extra fraction bits carried inside the core on x, y and residual angle.
  localparam int CORDIC_GUARD  = 4;
  // Width of one arctangent table entry (largest entry is 2^17).
  localparam int CORDIC_ATAN_W = 18;

  // Tag travelling alongside the core pipeline.
  typedef struct packed {
    logic valid;
    logic fold;
  } cordic_tag_t;

  localparam int CORDIC_TAG_W = $bits(cordic_tag_t);

  // atan(2^-idx) in units of 2^20 per full circle (angle LSB scaled by
  // 2^CORDIC_GUARD), rounded to nearest.
  function automatic logic [CORDIC_ATAN_W-1:0] cordic_atan(input int unsigned idx);
    logic [CORDIC_ATAN_W-1:0] val;
    case (idx)
      32'd0:   val = 18'd131072;
      32'd1:   val = 18'd77376;
      32'd2:   val = 18'd40884;
      32'd3:   val = 18'd20753;
      32'd4:   val = 18'd10417;
      32'd5:   val = 18'd5213;
      32'd6:   val = 18'd2607;
      32'd7:   val = 18'd1304;
      32'd8:   val = 18'd652;
      32'd9:   val = 18'd326;
      32'd10:  val = 18'd163;
      32'd11:  val = 18'd81;
      32'd12:  val = 18'd41;
      32'd13:  val = 18'd20;
      32'd14:  val = 18'd10;
      32'd15:  val = 18'd5;
      default: val = 18'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_quadrant_wrap_if.sv
// Signal bundle between the angle source / result consumer, the quadrant
// wrapper and the pipelined CORDIC core.
interface cordic_quadrant_wrap_if #(
  parameter int WIDTH = 16
);

  // Upstream angle stream.
  logic             in_valid;
  logic [WIDTH-1:0] in_angle;

  // Wrapper to core start vector.
  logic [WIDTH-1:0] core_x_start;
  logic [WIDTH-1:0] core_y_start;
  logic [WIDTH-1:0] core_angle;

  // Core results (y = sine, x = cosine).
  logic [WIDTH-1:0] core_sine;
  logic [WIDTH-1:0] core_cosine;

  // Downstream result stream.
  logic             out_valid;
  logic [WIDTH-1:0] out_sine;
  logic [WIDTH-1:0] out_cosine;

  // Angle producer / result consumer.
  modport master (
    output in_valid, in_angle,
    input  out_valid, out_sine, out_cosine
  );

  // Quadrant wrapper.
  modport slave (
    input  in_valid, in_angle,
    output core_x_start, core_y_start, core_angle,
    input  core_sine, core_cosine,
    output out_valid, out_sine, out_cosine
  );

  // Pipelined CORDIC core.
  modport core (
    input  core_x_start, core_y_start, core_angle,
    output core_sine, core_cosine
  );

endinterface

// File: rtl/cordic_sincos_core.sv
// Pipelined rotation-mode CORDIC: one micro-rotation per register stage,
// STAGES edges from input change to output change. No reset: contents after
// reset are garbage and are masked by the wrapper's cleared tags.
module cordic_sincos_core
  import cordic_pkg::*;
#(
  parameter int WIDTH  = CORDIC_WIDTH,
  parameter int STAGES = CORDIC_LATENCY
) (
  input logic               clock,
  cordic_quadrant_wrap_if.core bus
);

  localparam int G  = CORDIC_GUARD;
  // Two sign bits of headroom above the input width plus guard fraction bits.
  localparam int IW = WIDTH + G + 2;

  logic signed [IW-1:0] x_in_s;
  logic signed [IW-1:0] y_in_s;
  logic signed [IW-1:0] z_in_s;

  assign x_in_s = {{2{bus.core_x_start[WIDTH-1]}}, bus.core_x_start, {G{1'b0}}};
  assign y_in_s = {{2{bus.core_y_start[WIDTH-1]}}, bus.core_y_start, {G{1'b0}}};
  assign z_in_s = {{2{bus.core_angle[WIDTH-1]}},   bus.core_angle,   {G{1'b0}}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic signed [IW-1:0] x_prev_s;
    logic signed [IW-1:0] y_prev_s;
    logic signed [IW-1:0] z_prev_s;
    logic signed [IW-1:0] atan_s;
    logic signed [IW-1:0] x_q;
    logic signed [IW-1:0] y_q;

    if (k == 0) begin : g_src
      assign x_prev_s = x_in_s;
      assign y_prev_s = y_in_s;
      assign z_prev_s = z_in_s;
    end else begin : g_src
      assign x_prev_s = g_stage[k-1].x_q;
      assign y_prev_s = g_stage[k-1].y_q;
      assign z_prev_s = g_stage[k-1].g_z.z_q;
    end

    assign atan_s = {{(IW-CORDIC_ATAN_W){1'b0}}, cordic_atan(k)};

    // Micro-rotation k on x/y, direction set by the sign of the residual angle.
    always_ff @(posedge clock) begin
      if (z_prev_s[IW-1]) begin
        x_q <= x_prev_s + (y_prev_s >>> k);
        y_q <= y_prev_s - (x_prev_s >>> k);
      end else begin
        x_q <= x_prev_s - (y_prev_s >>> k);
        y_q <= y_prev_s + (x_prev_s >>> k);
      end
    end

    // The residual angle is only needed by the following stages.
    if (k < STAGES - 1) begin : g_z
      logic signed [IW-1:0] z_q;

      // Residual angle update matching the rotation direction chosen above.
      always_ff @(posedge clock) begin
        if (z_prev_s[IW-1]) begin
          z_q <= z_prev_s + atan_s;
        end else begin
          z_q <= z_prev_s - atan_s;
        end
      end
    end
  end

  // Drop guard bits (truncate) and headroom bits at the output.
  assign bus.core_cosine = g_stage[STAGES-1].x_q[G +: WIDTH];
  assign bus.core_sine   = g_stage[STAGES-1].y_q[G +: WIDTH];

  logic unused_core_bits_s;
  assign unused_core_bits_s = ^{g_stage[STAGES-1].x_q[IW-1:G+WIDTH], g_stage[STAGES-1].x_q[G-1:0],
                                g_stage[STAGES-1].y_q[IW-1:G+WIDTH], g_stage[STAGES-1].y_q[G-1:0]};

endmodule

// File: rtl/cordic_tag_delay.sv
// Fixed-depth shift register with asynchronous active-low clear; keeps a
// small tag aligned with a fixed-latency datapath.
module cordic_tag_delay #(
  parameter int DEPTH = 17,
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] stage_q [DEPTH];

  // Next state: new tag enters stage 0, every other stage takes its predecessor.
  always_comb begin
    stage_d[0] = data_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Shift register; reset clears every stage so no stale tag can emerge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cordic_quadrant_wrap.sv
// Full-circle front/back end for the +/-90 degree CORDIC core: folds the
// input angle by 180 degrees when |angle| >= 90 degrees, carries a
// {valid, fold} tag alongside the core and negates the core result for
// folded samples.
module cordic_quadrant_wrap
  import cordic_pkg::*;
#(
  parameter int               WIDTH     = CORDIC_WIDTH,
  parameter int               LATENCY   = CORDIC_LATENCY,
  parameter logic [WIDTH-1:0] GAIN_INIT = GAIN_INIT_Q14
) (
  input logic                   clock,
  input logic                   reset_n,
  cordic_quadrant_wrap_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's-complement negation, clamping the most negative code to the most
  // positive one instead of letting it wrap back onto itself.
  function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == SIGN_FLIP) begin
      r = ~SIGN_FLIP;
    end else begin
      r = ~v + ONE;
    end
    return r;
  endfunction

  logic             fold_s;
  logic [WIDTH-1:0] folded_angle_s;

  cordic_tag_t                 tag_in_s;
  cordic_tag_t                 tag_out_s;
  logic [CORDIC_TAG_W-1:0]     tag_out_bits_s;

  logic [WIDTH-1:0] core_x_start_d, core_x_start_q;
  logic [WIDTH-1:0] core_y_start_d, core_y_start_q;
  logic [WIDTH-1:0] core_angle_d,   core_angle_q;
  logic             out_valid_d,    out_valid_q;
  logic [WIDTH-1:0] out_sine_d,     out_sine_q;
  logic [WIDTH-1:0] out_cosine_d,   out_cosine_q;

  // Quadrants 2 and 3 (top two bits differ) are rotated by 180 degrees into
  // the core's convergence range; flipping the MSB adds 180 degrees mod 360.
  always_comb begin
    fold_s = bus.in_angle[WIDTH-1] ^ bus.in_angle[WIDTH-2];
    if (fold_s) begin
      folded_angle_s = bus.in_angle ^ SIGN_FLIP;
    end else begin
      folded_angle_s = bus.in_angle;
    end
    tag_in_s.valid = bus.in_valid;
    tag_in_s.fold  = fold_s;
  end

  // Tag delay is one deeper than the core so it lines up with the core output
  // in the same cycle the output register samples it.
  cordic_tag_delay #(
    .DEPTH (LATENCY + 1),
    .WIDTH (CORDIC_TAG_W)
  ) u_tag_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .data_i  (tag_in_s),
    .data_o  (tag_out_bits_s)
  );

  assign tag_out_s = cordic_tag_t'(tag_out_bits_s);

  // Next state for the core start vector and the sign-corrected result.
  always_comb begin
    core_x_start_d = GAIN_INIT;
    core_y_start_d = ZERO;
    if (bus.in_valid) begin
      core_angle_d = folded_angle_s;
    end else begin
      core_angle_d = core_angle_q;
    end

    out_valid_d = tag_out_s.valid;
    if (tag_out_s.fold) begin
      out_sine_d   = sat_neg(bus.core_sine);
      out_cosine_d = sat_neg(bus.core_cosine);
    end else begin
      out_sine_d   = bus.core_sine;
      out_cosine_d = bus.core_cosine;
    end
  end

  // Registers for the core start vector and the result; reset zeroes all.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      core_x_start_q <= ZERO;
      core_y_start_q <= ZERO;
      core_angle_q   <= ZERO;
      out_valid_q    <= 1'b0;
      out_sine_q     <= ZERO;
      out_cosine_q   <= ZERO;
    end else begin
      core_x_start_q <= core_x_start_d;
      core_y_start_q <= core_y_start_d;
      core_angle_q   <= core_angle_d;
      out_valid_q    <= out_valid_d;
      out_sine_q     <= out_sine_d;
      out_cosine_q   <= out_cosine_d;
    end
  end

  assign bus.core_x_start = core_x_start_q;
  assign bus.core_y_start = core_y_start_q;
  assign bus.core_angle   = core_angle_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sine     = out_sine_q;
  assign bus.out_cosine   = out_cosine_q;

endmodule

// File: tb/tb_cordic_quadrant_wrap.sv
// Bench for cordic_quadrant_wrap driving the real pipelined core. Stimulus
// pushes expected results into a scoreboard queue; an independent monitor
// pops and compares against real-valued sin/cos whenever out_valid is seen.
module tb_cordic_quadrant_wrap;

  localparam int          W     = 16;
  localparam int          LAT   = 17;
  localparam int          TOL   = 8;
  localparam logic [15:0] GAIN  = 16'h26DD;
  localparam real         PI    = 3.14159265358979323846;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  cordic_quadrant_wrap_if #(.WIDTH(W)) bus ();

  cordic_quadrant_wrap #(
    .WIDTH     (W),
    .LATENCY   (16),
    .GAIN_INIT (GAIN)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  cordic_sincos_core #(
    .WIDTH  (W),
    .STAGES (16)
  ) u_core (
    .clock (clock),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] angle;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          edge_cnt  = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;
  logic [15:0] exp_core_angle = 16'h0000;

  function automatic int ref_sin(input logic [15:0] a);
    int  ai;
    real r;
    ai = $signed(a);
    r  = ai * PI / 32768.0;
    return int'(16384.0 * $sin(r));
  endfunction

  function automatic int ref_cos(input logic [15:0] a);
    int  ai;
    real r;
    ai = $signed(a);
    r  = ai * PI / 32768.0;
    return int'(16384.0 * $cos(r));
  endfunction

  // Angle seen by the core: half-turn added when |angle| >= 90 degrees.
  function automatic logic [15:0] ref_fold(input logic [15:0] a);
    int s;
    s = $signed(a);
    if (s >= 16384 || s < -16384) s = s + 32768;
    return 16'(s);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, edge_cnt);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      edge_cnt++;
    end
  end

  // Monitor: compares every presented result against the scoreboard.
  initial begin
    exp_t e;
    int   s;
    int   c;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        check("out_valid_in_reset", bus.out_valid == 1'b0, int'(bus.out_valid), 0);
      end else if (bus.out_valid) begin
        check("out_valid_expected", sb_q.size() != 0, int'(bus.out_valid), sb_q.size());
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          s = $signed(bus.out_sine);
          c = $signed(bus.out_cosine);
          check("latency", edge_cnt == e.due, edge_cnt, e.due);
          check("sine", iabs(s - ref_sin(e.angle)) <= TOL, s, ref_sin(e.angle));
          check("cosine", iabs(c - ref_cos(e.angle)) <= TOL, c, ref_cos(e.angle));
        end
      end else if (sb_q.size() != 0) begin
        check("out_valid_on_time", sb_q[0].due > edge_cnt, edge_cnt, sb_q[0].due);
        if (sb_q[0].due <= edge_cnt) void'(sb_q.pop_front());
      end
    end
  end

  // One input cycle, entered and left at a falling edge.
  task automatic drive_cycle(input bit v, input logic [15:0] a);
    exp_t e;
    bus.in_valid = v;
    bus.in_angle = a;
    if (v) begin
      e.angle = a;
      e.due   = edge_cnt + 1 + LAT;
      sb_q.push_back(e);
      exp_core_angle = ref_fold(a);
    end
    @(posedge clock);
    #1;
    check("core_angle", bus.core_angle == exp_core_angle, int'(bus.core_angle), int'(exp_core_angle));
    check("core_x_start", bus.core_x_start == GAIN, int'(bus.core_x_start), int'(GAIN));
    check("core_y_start", bus.core_y_start == 16'h0000, int'(bus.core_y_start), 0);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'($urandom()));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"},    bus.out_valid == 1'b0,        int'(bus.out_valid), 0);
    check({tag, "_out_sine"},     bus.out_sine == 16'h0000,     int'(bus.out_sine), 0);
    check({tag, "_out_cosine"},   bus.out_cosine == 16'h0000,   int'(bus.out_cosine), 0);
    check({tag, "_core_angle"},   bus.core_angle == 16'h0000,   int'(bus.core_angle), 0);
    check({tag, "_core_x_start"}, bus.core_x_start == 16'h0000, int'(bus.core_x_start), 0);
    check({tag, "_core_y_start"}, bus.core_y_start == 16'h0000, int'(bus.core_y_start), 0);
  endtask

  initial begin
    logic [15:0] bounds [8];
    int          waited;
    bounds = '{16'h4000, 16'h8000, 16'hC000, 16'h3FFF, 16'hBFFF, 16'h4001, 16'h7FFF, 16'h0000};

    bus.in_valid = 1'b0;
    bus.in_angle = 16'h0000;
    repeat (2) @(negedge clock);
    check_reset_values("por");
    reset_n = 1'b1;
    idle(1);

    // Single 45-degree sample, then quiet so any extra pulse is caught.
    drive_cycle(1'b1, 16'h2000);
    idle(20);

    // 135 degrees; core_angle must hold through the idle cycles.
    drive_cycle(1'b1, 16'h6000);
    idle(3);

    // Quadrant boundaries back to back.
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, bounds[i]);
    idle(20);

    // Random sweep with in_valid pattern 1,1,0,1.
    for (int i = 0; i < 64; i++) drive_cycle((i % 4) != 2, 16'($urandom()));
    idle(20);

    // Fill the pipeline, then reset asynchronously mid-cycle.
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 16'($urandom()));
    bus.in_valid = 1'b0;
    @(posedge clock);
    #2;
    check("out_valid_before_reset", bus.out_valid == 1'b1, int'(bus.out_valid), 1);
    reset_n = 1'b0;
    sb_q.delete();
    exp_core_angle = 16'h0000;
    #1;
    check_reset_values("async");
    repeat (3) @(negedge clock);

    // Release with a valid sample on the very first edge.
    reset_n = 1'b1;
    drive_cycle(1'b1, 16'hA000);
    idle(25);

    waited = 0;
    while (sb_q.size() != 0 && waited < 100) begin
      idle(1);
      waited++;
    end
    check("drain", sb_q.size() == 0, sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
